// File: rtl/ervp_platform_reg_apb_arbiter_pkg.sv
// Shared types for the platform register APB arbiter: FSM encoding, timeout counter width, grant index width.
// No logic; latency and backpressure not applicable.
// Imported by the arbiter top and the round-robin picker.
package ervp_platform_reg_apb_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } arb_state_e;

    localparam int TO_CNT_W = 8;

    function automatic int gid_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ervp_rr_picker.sv
// Round-robin picker: lowest requester strictly above last_i wins, else lowest requester overall.
// Latency: purely combinational.
// Backpressure: none; an all-zero request vector yields an all-zero one-hot.
module ervp_rr_picker
    import ervp_platform_reg_apb_arbiter_pkg::*;
#(
    parameter int NUM_MASTER = 4,
    parameter int IDX_W      = gid_width(NUM_MASTER)
) (
    input  logic [NUM_MASTER-1:0] req_i,
    input  logic [IDX_W-1:0]      last_i,
    output logic [NUM_MASTER-1:0] win_oh_o,
    output logic [IDX_W-1:0]      win_idx_o
);

    logic             hit_hi;
    logic             hit_lo;
    logic [IDX_W-1:0] idx_hi;
    logic [IDX_W-1:0] idx_lo;

    // Descending scan so the final assignment holds the lowest matching index.
    always_comb begin
        hit_hi = 1'b0;
        hit_lo = 1'b0;
        idx_hi = '0;
        idx_lo = '0;
        for (int i = NUM_MASTER - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                hit_lo = 1'b1;
                idx_lo = IDX_W'(i);
                if (IDX_W'(i) > last_i) begin
                    hit_hi = 1'b1;
                    idx_hi = IDX_W'(i);
                end
            end
        end
    end

    always_comb begin
        win_idx_o = hit_hi ? idx_hi : idx_lo;
        win_oh_o  = '0;
        for (int i = 0; i < NUM_MASTER; i++) begin
            win_oh_o[i] = hit_lo && (win_idx_o == IDX_W'(i));
        end
    end

endmodule

// File: rtl/ervp_platform_reg_apb_arbiter.sv
// Round-robin arbiter sharing one APB slave port among NUM_MASTER masters; optional watchdog via PLATFORM_APB_ARB_TIMEOUT_EN.
// Latency: request in IDLE -> SETUP next cycle -> ACCESS after that; 3 cycles minimum plus m_pready wait cycles.
// Backpressure: losing masters see s_pready=0 and hold s_psel; the winner waits on m_pready (or the watchdog).
module ervp_platform_reg_apb_arbiter
    import ervp_platform_reg_apb_arbiter_pkg::*;
#(
    parameter int NUM_MASTER     = 4,
    parameter int BW_ADDR        = 12,
    parameter int BW_DATA        = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_MASTER-1:0]           s_psel,
    input  logic [NUM_MASTER-1:0]           s_penable,
    input  logic [NUM_MASTER*BW_ADDR-1:0]   s_paddr,
    input  logic [NUM_MASTER-1:0]           s_pwrite,
    input  logic [NUM_MASTER*BW_DATA-1:0]   s_pwdata,
    output logic [BW_DATA-1:0]              s_prdata,
    output logic [NUM_MASTER-1:0]           s_pready,
    output logic [NUM_MASTER-1:0]           s_pslverr,
    output logic                            m_psel,
    output logic                            m_penable,
    output logic                            m_pwrite,
    output logic [BW_ADDR-1:0]              m_paddr,
    output logic [BW_DATA-1:0]              m_pwdata,
    input  logic [BW_DATA-1:0]              m_prdata,
    input  logic                            m_pready,
    input  logic                            m_pslverr,
    output logic [gid_width(NUM_MASTER)-1:0] grant_id,
    output logic                            busy,
    output logic [TO_CNT_W-1:0]             timeout_count
);

    localparam int               GID_W   = gid_width(NUM_MASTER);
    localparam logic [GID_W-1:0] GID_RST = GID_W'(NUM_MASTER - 1);

    arb_state_e           state_q, state_d;
    logic [GID_W-1:0]     gid_q, gid_d;
    logic [BW_ADDR-1:0]   addr_q, addr_d;
    logic                 write_q, write_d;
    logic [BW_DATA-1:0]   wdata_q, wdata_d;
    logic [NUM_MASTER-1:0] win_oh;
    logic [GID_W-1:0]     win_idx;
    logic                 any_req;
    logic                 to_hit;
    logic                 unused_penable;

    // Masters' penable carries no information the arbiter needs: psel alone marks a pending transfer.
    assign unused_penable = ^s_penable;

    ervp_rr_picker #(
        .NUM_MASTER (NUM_MASTER),
        .IDX_W      (GID_W)
    ) u_picker (
        .req_i     (s_psel),
        .last_i    (gid_q),
        .win_oh_o  (win_oh),
        .win_idx_o (win_idx)
    );

    assign any_req = |win_oh;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gid_q   <= GID_RST;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            gid_q   <= gid_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (any_req) state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: if (m_pready || to_hit) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // The winner's request is captured once so the shared port stays stable even if the master wiggles its inputs.
    always_comb begin
        gid_d   = gid_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        if (state_q == ST_IDLE && any_req) begin
            gid_d = win_idx;
            for (int i = 0; i < NUM_MASTER; i++) begin
                if (win_oh[i]) begin
                    addr_d  = s_paddr[i*BW_ADDR +: BW_ADDR];
                    write_d = s_pwrite[i];
                    wdata_d = s_pwdata[i*BW_DATA +: BW_DATA];
                end
            end
        end
    end

    always_comb begin
        m_psel    = 1'b0;
        m_penable = 1'b0;
        s_pready  = '0;
        s_pslverr = '0;
        s_prdata  = '0;
        case (state_q)
            ST_SETUP: m_psel = 1'b1;
            ST_ACCESS: begin
                m_psel    = !to_hit;
                m_penable = !to_hit;
                if (m_pready) begin
                    s_pready[gid_q]  = 1'b1;
                    s_pslverr[gid_q] = m_pslverr;
                    s_prdata         = m_prdata;
                end else if (to_hit) begin
                    s_pready[gid_q]  = 1'b1;
                    s_pslverr[gid_q] = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign m_paddr  = addr_q;
    assign m_pwrite = write_q;
    assign m_pwdata = wdata_q;
    assign grant_id = gid_q;
    assign busy     = (state_q != ST_IDLE);

`ifdef PLATFORM_APB_ARB_TIMEOUT_EN
    logic [TO_CNT_W-1:0] to_cnt_q, to_cnt_d;
    logic [TO_CNT_W-1:0] to_tot_q, to_tot_d;

    // to_cnt_q equals the number of ACCESS cycles already spent without a ready.
    assign to_hit = (state_q == ST_ACCESS) && !m_pready &&
                    (to_cnt_q == TO_CNT_W'(TIMEOUT_CYCLES));

    always_comb begin
        to_cnt_d = (state_q == ST_ACCESS) ? to_cnt_q + TO_CNT_W'(1) : '0;
        to_tot_d = to_tot_q;
        if (to_hit && (to_tot_q != '1)) begin
            to_tot_d = to_tot_q + TO_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q <= '0;
            to_tot_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
            to_tot_q <= to_tot_d;
        end
    end

    assign timeout_count = to_tot_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign to_hit             = 1'b0;
    assign timeout_count      = '0;
`endif

endmodule

// File: tb/tb_ervp_platform_reg_apb_arbiter.sv
// Directed bench for the APB arbiter: reset state, single write, rotating reads, wait/error response, reset mid-access.
// The watchdog scenario is exercised when PLATFORM_APB_ARB_TIMEOUT_EN is defined.
module tb_ervp_platform_reg_apb_arbiter;

    localparam int NM = 4;
    localparam int AW = 12;
    localparam int DW = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [NM-1:0]    s_psel, s_penable, s_pwrite, s_pready, s_pslverr;
    logic [NM*AW-1:0] s_paddr;
    logic [NM*DW-1:0] s_pwdata;
    logic [DW-1:0]    s_prdata, m_pwdata, m_prdata;
    logic             m_psel, m_penable, m_pwrite, m_pready, m_pslverr;
    logic [AW-1:0]    m_paddr;
    logic [1:0]       grant_id;
    logic             busy;
    logic [7:0]       timeout_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Slave model: read data is a fixed tag OR'ed with the presented address.
    assign m_prdata = 32'hA000_0000 | {20'h0, m_paddr};

    ervp_platform_reg_apb_arbiter #(
        .NUM_MASTER     (NM),
        .BW_ADDR        (AW),
        .BW_DATA        (DW),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_psel        (s_psel),
        .s_penable     (s_penable),
        .s_paddr       (s_paddr),
        .s_pwrite      (s_pwrite),
        .s_pwdata      (s_pwdata),
        .s_prdata      (s_prdata),
        .s_pready      (s_pready),
        .s_pslverr     (s_pslverr),
        .m_psel        (m_psel),
        .m_penable     (m_penable),
        .m_pwrite      (m_pwrite),
        .m_paddr       (m_paddr),
        .m_pwdata      (m_pwdata),
        .m_prdata      (m_prdata),
        .m_pready      (m_pready),
        .m_pslverr     (m_pslverr),
        .grant_id      (grant_id),
        .busy          (busy),
        .timeout_count (timeout_count)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc_start();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rdy(input string tag, input int limit);
        int n;
        n = 0;
        @(negedge clk);
        while (s_pready == '0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_seen"}, 64'(s_pready != '0), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "bench time limit exceeded");
    end

    initial begin
        logic [NM-1:0] seen_rdy;
        logic [NM-1:0] seen_err;
        int            e;

        rst = 1'b1; s_psel = '0; s_penable = '0; s_pwrite = '0;
        s_paddr = '0; s_pwdata = '0; m_pready = 1'b1; m_pslverr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_psel",    64'(m_psel),        64'(0));
        chk("rst_penable", 64'(m_penable),     64'(0));
        chk("rst_busy",    64'(busy),          64'(0));
        chk("rst_gid",     64'(grant_id),      64'(3));
        chk("rst_tocnt",   64'(timeout_count), 64'(0));
        chk("rst_pready",  64'(s_pready),      64'(0));
        chk("rst_prdata",  64'(s_prdata),      64'(0));
        chk("rst_paddr",   64'(m_paddr),       64'(0));
        chk("rst_pwdata",  64'(m_pwdata),      64'(0));

        // Master 1 writes 0xDEADBEEF to 0x010
        cyc_start();
        s_psel = 4'b0010; s_pwrite = 4'b0010;
        s_paddr[1*AW +: AW] = 12'h010;
        s_pwdata[1*DW +: DW] = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("t1_c0_psel", 64'(m_psel), 64'(0));
        cyc_start();
        s_penable = 4'b0010;
        @(negedge clk);
        chk("t1_c1_psel",    64'(m_psel),    64'(1));
        chk("t1_c1_penable", 64'(m_penable), 64'(0));
        chk("t1_c1_gid",     64'(grant_id),  64'(1));
        chk("t1_c1_paddr",   64'(m_paddr),   64'(12'h010));
        chk("t1_c1_pwrite",  64'(m_pwrite),  64'(1));
        chk("t1_c1_prdata",  64'(s_prdata),  64'(0));
        chk("t1_c1_busy",    64'(busy),      64'(1));
        cyc_start();
        s_paddr[1*AW +: AW] = 12'hFFF;
        @(negedge clk);
        chk("t1_c2_penable", 64'(m_penable), 64'(1));
        chk("t1_c2_paddr",   64'(m_paddr),   64'(12'h010));
        chk("t1_c2_pwdata",  64'(m_pwdata),  64'(32'hDEAD_BEEF));
        chk("t1_c2_pready",  64'(s_pready),  64'(4'b0010));
        chk("t1_c2_pslverr", 64'(s_pslverr), 64'(0));
        cyc_start();
        s_psel = '0; s_penable = '0; s_pwrite = '0;
        @(negedge clk);
        chk("t1_c3_busy", 64'(busy),   64'(0));
        chk("t1_c3_psel", 64'(m_psel), 64'(0));

        // All four masters read continuously from a fresh reset
        cyc_start();
        rst = 1'b1;
        cyc_start();
        rst = 1'b0;
        for (int i = 0; i < NM; i++) s_paddr[i*AW +: AW] = AW'(12'h100 + 4 * i);
        s_psel = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            e = t % NM;
            wait_rdy("t2", 10);
            chk("t2_rdy",   64'(s_pready), 64'(4'b0001 << e));
            chk("t2_rdata", 64'(s_prdata), 64'(32'hA000_0100 + 4 * e));
            chk("t2_gid",   64'(grant_id), 64'(e));
            cyc_start();
            if (t == 4) s_psel = '0;
            @(negedge clk);
            chk("t2_gap_busy", 64'(busy), 64'(0));
        end

        // Master 2 read with 5 wait cycles and an error response
        cyc_start();
        s_psel = 4'b0100; s_paddr[2*AW +: AW] = 12'h020;
        m_pready = 1'b0; m_pslverr = 1'b1;
        seen_rdy = '0; seen_err = '0;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            seen_rdy |= s_pready;
            seen_err |= s_pslverr;
            if (c == 6) chk("t3_c6_penable", 64'(m_penable), 64'(1));
            if (c < 6) cyc_start();
        end
        chk("t3_early_rdy", 64'(seen_rdy), 64'(0));
        chk("t3_early_err", 64'(seen_err), 64'(0));
        cyc_start();
        m_pready = 1'b1;
        @(negedge clk);
        chk("t3_rdy",   64'(s_pready),  64'(4'b0100));
        chk("t3_err",   64'(s_pslverr), 64'(4'b0100));
        chk("t3_rdata", 64'(s_prdata),  64'(32'hA000_0020));
        chk("t3_gid",   64'(grant_id),  64'(2));
        cyc_start();
        s_psel = '0; m_pslverr = 1'b0;
        @(negedge clk);
        chk("t3_busy", 64'(busy), 64'(0));

`ifdef PLATFORM_APB_ARB_TIMEOUT_EN
        // Master 3 access never completes: watchdog aborts after 8 ACCESS cycles
        cyc_start();
        s_psel = 4'b1000; m_pready = 1'b0;
        seen_rdy = '0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            seen_rdy |= s_pready;
            if (c == 9) chk("to_c9_penable", 64'(m_penable), 64'(1));
            if (c < 9) cyc_start();
        end
        chk("to_early_rdy", 64'(seen_rdy), 64'(0));
        cyc_start();
        @(negedge clk);
        chk("to_rdy",    64'(s_pready),  64'(4'b1000));
        chk("to_err",    64'(s_pslverr), 64'(4'b1000));
        chk("to_prdata", 64'(s_prdata),  64'(0));
        chk("to_psel",   64'(m_psel),    64'(0));
        cyc_start();
        s_psel = '0; m_pready = 1'b1;
        @(negedge clk);
        chk("to_busy",  64'(busy),          64'(0));
        chk("to_count", 64'(timeout_count), 64'(1));
`endif

        // Reset pulsed while master 1 is in ACCESS
        cyc_start();
        s_psel = 4'b0010; m_pready = 1'b0;
        @(negedge clk);
        cyc_start();
        @(negedge clk);
        cyc_start();
        rst = 1'b1;
        @(negedge clk);
        chk("t5_access", 64'(m_penable), 64'(1));
        chk("t5_gid1",   64'(grant_id),  64'(1));
        cyc_start();
        rst = 1'b0; s_psel = 4'b0101; m_pready = 1'b1;
        @(negedge clk);
        chk("t5_psel",   64'(m_psel),        64'(0));
        chk("t5_gid",    64'(grant_id),      64'(3));
        chk("t5_busy",   64'(busy),          64'(0));
        chk("t5_pready", 64'(s_pready),      64'(0));
        chk("t5_tocnt",  64'(timeout_count), 64'(0));
        wait_rdy("t5", 10);
        chk("t5_rdy",    64'(s_pready), 64'(4'b0001));
        chk("t5_gid0",   64'(grant_id), 64'(0));
        cyc_start();
        s_psel = '0;
        @(negedge clk);
        chk("t5_end_busy", 64'(busy), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
